// File: rtl/mat_load_if.sv
// Stream/load bundle between the matrix source and mat_load_ctrl.
// master: drives matw/src_valid; slave: mat_load_ctrl, drives the rest.
interface mat_load_if #(
    parameter int NUM_CORES = 4,
    parameter int ADDR_W    = 6
);
    logic                 matw;
    logic                 src_valid;
    logic                 src_ready;
    logic [NUM_CORES-1:0] mat_v;
    logic [ADDR_W-1:0]    mat_a;
    logic                 busy;
    logic                 done;

    modport master (
        output matw, src_valid,
        input  src_ready, mat_v, mat_a, busy, done
    );

    modport slave (
        input  matw, src_valid,
        output src_ready, mat_v, mat_a, busy, done
    );
endinterface

// File: rtl/mat_load_ctrl.sv
// Matrix-load sequencer: steers accepted stream beats to N cores in turn.
// Ports: clk, rst_n (async low), bus (mat_load_if.slave): matw, src_valid,
// src_ready, mat_v, mat_a, busy, done. Option MAT_LOAD_BCAST_EN adds bcast.
module mat_load_ctrl #(
    parameter int NUM_CORES      = 4,
    parameter int WORDS_PER_CORE = 2,
    parameter int ADDR_STEP      = 32,
    parameter int ADDR_W         = 6
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef MAT_LOAD_BCAST_EN
    input  logic        bcast,
`endif
    mat_load_if.slave   bus
);
    localparam int CS_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int BC_W = (WORDS_PER_CORE > 1) ? $clog2(WORDS_PER_CORE) : 1;
    localparam logic [CS_W-1:0]   LAST_CORE = CS_W'(NUM_CORES - 1);
    localparam logic [BC_W-1:0]   LAST_BEAT = BC_W'(WORDS_PER_CORE - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_e;

    state_e              state_q, state_d;
    logic [CS_W-1:0]     core_sel_q, core_sel_d;
    logic [BC_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic [ADDR_W-1:0]   mat_a_q, mat_a_d;
    logic                bc;
    logic                src_ready;
    logic                accept;
    logic [NUM_CORES-1:0] mat_v;

`ifdef MAT_LOAD_BCAST_EN
    logic bcast_q, bcast_d;

    // Broadcast mode is frozen for the whole load at the start edge.
    assign bcast_d = (state_q == S_IDLE && bus.matw) ? bcast : bcast_q;
    assign bc      = bcast_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bcast_q <= 1'b0;
        else        bcast_q <= bcast_d;
    end
`else
    assign bc = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            core_sel_q <= '0;
            beat_cnt_q <= '0;
            mat_a_q    <= '0;
        end else begin
            state_q    <= state_d;
            core_sel_q <= core_sel_d;
            beat_cnt_q <= beat_cnt_d;
            mat_a_q    <= mat_a_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_sel_d = core_sel_q;
        beat_cnt_d = beat_cnt_q;
        mat_a_d    = mat_a_q;
        src_ready  = 1'b0;
        accept     = 1'b0;
        mat_v      = '0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.matw) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                src_ready = bus.matw;
                accept    = bus.src_valid & bus.matw;
                if (!bus.matw) begin
                    // Abort: drop the partial load entirely.
                    state_d    = S_IDLE;
                    core_sel_d = '0;
                    beat_cnt_d = '0;
                    mat_a_d    = '0;
                end else if (accept) begin
                    mat_v = bc ? {NUM_CORES{1'b1}}
                               : (NUM_CORES'(1) << core_sel_q);
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        mat_a_d    = '0;
                        if (bc || core_sel_q == LAST_CORE) begin
                            state_d    = S_DONE;
                            core_sel_d = '0;
                        end else begin
                            core_sel_d = core_sel_q + 1'b1;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                        mat_a_d    = mat_a_q + STEP;
                    end
                end
            end
            S_DONE: begin
                if (!bus.matw) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign bus.src_ready = src_ready;
    assign bus.mat_v     = mat_v;
    assign bus.mat_a     = mat_a_q;
    assign bus.busy      = (state_q == S_LOAD);
    assign bus.done      = (state_q == S_DONE);
endmodule

// File: tb/tb_mat_load_ctrl.sv
// Randomised self-checking bench for mat_load_ctrl against a beat-count model.
// Two instances: default geometry and WORDS_PER_CORE=4 for address wrap.
module tb_mat_load_ctrl;
    localparam int N  = 4;
    localparam int W  = 2;
    localparam int W2 = 4;

    logic clk;
    logic rst_n;
    logic bcast_in;

    mat_load_if #(.NUM_CORES(N), .ADDR_W(6)) ifc ();
    mat_load_if #(.NUM_CORES(N), .ADDR_W(6)) ifc2 ();

    mat_load_ctrl #(
        .NUM_CORES(N), .WORDS_PER_CORE(W), .ADDR_STEP(32), .ADDR_W(6)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MAT_LOAD_BCAST_EN
        .bcast(bcast_in),
`endif
        .bus(ifc)
    );

    mat_load_ctrl #(
        .NUM_CORES(N), .WORDS_PER_CORE(W2), .ADDR_STEP(32), .ADDR_W(6)
    ) dut2 (
        .clk(clk),
        .rst_n(rst_n),
`ifdef MAT_LOAD_BCAST_EN
        .bcast(1'b0),
`endif
        .bus(ifc2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: phase 0 idle, 1 loading, 2 finished; k = beats accepted so far.
    int m_ph, m_k, m2_ph, m2_k;
    bit m_b, m2_b;
    logic [12:0] exp_v, got_v;

    // Beat k of a load lands on core k/w at offset (k%w)*32 mod 64.
    function automatic logic [12:0] model_out(int ph, int k, int w, bit b,
                                              bit m, bit vld);
        logic rdy, acc;
        logic [3:0] v;
        logic [5:0] a;
        rdy = (ph == 1) && m;
        acc = rdy && vld;
        v = 4'h0;
        if (acc) v = b ? 4'hF : 4'(1 << (k / w));
        a = (ph == 1) ? 6'(((k % w) * 32) % 64) : 6'd0;
        return {rdy, v, a, ph == 1, ph == 2};
    endfunction

    task automatic model_step(inout int ph, inout int k, inout bit b,
                              input int w, input bit bc, input bit m,
                              input bit vld);
        int total;
        total = b ? w : N * w;
        case (ph)
            0: if (m) begin ph = 1; k = 0; b = bc; end
            1: begin
                if (!m) ph = 0;
                else if (vld) begin
                    k++;
                    if (k == total) ph = 2;
                end
            end
            default: if (!m) ph = 0;
        endcase
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        ifc.matw = 1'b1; ifc.src_valid = 1'b1;
        ifc2.matw = 1'b1; ifc2.src_valid = 1'b1;
        bcast_in = 1'b0;
        m_ph = 0; m_k = 0; m_b = 0;
        m2_ph = 0; m2_k = 0; m2_b = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
        checks++;
        if (got_v !== 13'h0) begin
            failures++;
            $display("FAIL reset dut got=%h exp=0", got_v);
        end
        got_v = {ifc2.src_ready, ifc2.mat_v, ifc2.mat_a, ifc2.busy, ifc2.done};
        checks++;
        if (got_v !== 13'h0) begin
            failures++;
            $display("FAIL reset dut2 got=%h exp=0", got_v);
        end
        @(posedge clk); #1;
        ifc.matw = 1'b0; ifc.src_valid = 1'b0;
        ifc2.matw = 1'b0; ifc2.src_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_full_load();
        for (int i = 0; i < 14; i++) begin
            ifc.matw = (i < 12);
            ifc.src_valid = 1'b1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL full_load cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_gaps();
        int i;
        bit seen_done;
        seen_done = 0;
        i = 0;
        while (i < 80 && !(seen_done && m_ph == 0)) begin
            ifc.matw = !(m_ph == 2);
            ifc.src_valid = ($urandom_range(0, 2) == 0);
            if (m_ph == 2) seen_done = 1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL gaps cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL gaps_timeout got=no_done exp=done");
        end
    endtask

    task automatic test_abort();
        bit pm [0:11];
        pm = '{1, 1, 1, 1, 0, 0, 1, 1, 1, 0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            ifc.matw = pm[i];
            ifc.src_valid = 1'b1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL abort cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 6; i++) begin
            ifc.matw = 1'b1;
            ifc.src_valid = 1'b1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL areset_pre cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
        end
        #1 rst_n = 1'b0;
        #1;
        got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
        checks++;
        if (got_v !== 13'h0) begin
            failures++;
            $display("FAIL areset_now got=%h exp=0", got_v);
        end
        m_ph = 0; m_k = 0; m_b = 0;
        m2_ph = 0; m2_k = 0; m2_b = 0;
        ifc.matw = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 12; i++) begin
            ifc.matw = (i < 10);
            ifc.src_valid = 1'b1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL areset_post cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            ifc.matw = ($urandom_range(0, 9) != 0);
            ifc.src_valid = $urandom_range(0, 1);
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL random cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            @(posedge clk); #1;
        end
        ifc.matw = 1'b0;
        ifc.src_valid = 1'b0;
        @(posedge clk); #1;
        m_ph = (m_ph == 0) ? 0 : 0;
        @(posedge clk); #1;
    endtask

    task automatic test_wrap();
        int i;
        bit seen_done;
        seen_done = 0;
        i = 0;
        while (i < 100 && !(seen_done && m2_ph == 0)) begin
            ifc2.matw = !(m2_ph == 2);
            ifc2.src_valid = ($urandom_range(0, 3) != 0);
            if (m2_ph == 2) seen_done = 1;
            @(negedge clk);
            exp_v = model_out(m2_ph, m2_k, W2, m2_b, ifc2.matw, ifc2.src_valid);
            got_v = {ifc2.src_ready, ifc2.mat_v, ifc2.mat_a, ifc2.busy, ifc2.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL wrap cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m2_ph, m2_k, m2_b, W2, 1'b0, ifc2.matw, ifc2.src_valid);
            @(posedge clk); #1;
            i++;
        end
        checks++;
        if (!seen_done) begin
            failures++;
            $display("FAIL wrap_timeout got=no_done exp=done");
        end
    endtask

`ifdef MAT_LOAD_BCAST_EN
    task automatic test_bcast();
        bcast_in = 1'b1;
        for (int i = 0; i < 7; i++) begin
            ifc.matw = (i < 5);
            ifc.src_valid = 1'b1;
            @(negedge clk);
            exp_v = model_out(m_ph, m_k, W, m_b, ifc.matw, ifc.src_valid);
            got_v = {ifc.src_ready, ifc.mat_v, ifc.mat_a, ifc.busy, ifc.done};
            checks++;
            if (got_v !== exp_v) begin
                failures++;
                $display("FAIL bcast cyc=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            model_step(m_ph, m_k, m_b, W, bcast_in, ifc.matw, ifc.src_valid);
            if (i == 0) bcast_in = 1'b0;
            @(posedge clk); #1;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_load();
        test_gaps();
        test_abort();
        test_async_reset();
        test_random();
        test_wrap();
`ifdef MAT_LOAD_BCAST_EN
        test_bcast();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
